// File: rtl/uart_pkg.sv
// Shared constants, FSM encoding and helpers for the UART matrix printer and its TX core.
package uart_pkg;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;

  localparam logic [16:0] W_10000 = 17'd10000;
  localparam logic [16:0] W_1000  = 17'd1000;
  localparam logic [16:0] W_100   = 17'd100;
  localparam logic [16:0] W_10    = 17'd10;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_CONV,
    ST_SEND_SIGN,
    ST_SEND_DIG,
    ST_SEND_SEP,
    ST_SEND_CR,
    ST_SEND_LF,
    ST_DONE
  } state_e;

  // Slot 0 holds the ten-thousands digit, slot 4 the units digit.
  typedef logic [4:0][3:0] digits_t;

  function automatic int unsigned baud_div(input int unsigned clk_freq, input int unsigned baud);
    return clk_freq / baud;
  endfunction

  function automatic logic [16:0] dec_weight(input logic [2:0] idx);
    logic [16:0] w;
    case (idx)
      3'd0:    w = W_10000;
      3'd1:    w = W_1000;
      3'd2:    w = W_100;
      default: w = W_10;
    endcase
    return w;
  endfunction

  // Index of the first printable digit; the units digit is always printed.
  function automatic logic [2:0] first_digit(input digits_t d);
    logic [2:0] idx;
    idx = 3'd4;
    for (int i = 3; i >= 0; i--) begin
      if (d[i] != 4'd0) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/uart_tx_core.sv
// 8N1 UART transmitter: one byte per tx_start pulse, LSB first, line idles high.
module uart_tx_core #(
  parameter int unsigned DIV = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       tx
);
  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] baud_q;
  logic [3:0]    bit_q;
  logic [9:0]    shift_q;
  logic          busy_q;
  logic          tx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '1;
      busy_q  <= 1'b0;
      tx_q    <= 1'b1;
    end else if (!busy_q) begin
      if (tx_start) begin
        busy_q  <= 1'b1;
        shift_q <= {1'b1, tx_data, 1'b0};
        tx_q    <= 1'b0;
        baud_q  <= '0;
        bit_q   <= '0;
      end
    end else if (baud_q == CW'(DIV - 1)) begin
      baud_q <= '0;
      if (bit_q == 4'd9) begin
        busy_q <= 1'b0;
        tx_q   <= 1'b1;
      end else begin
        bit_q   <= bit_q + 4'd1;
        tx_q    <= shift_q[1];
        shift_q <= {1'b1, shift_q[9:1]};
      end
    end else begin
      baud_q <= baud_q + CW'(1);
    end
  end

  assign tx_busy = busy_q;
  assign tx      = tx_q;

endmodule

// File: rtl/uart_matrix_printer.sv
// Reads an m x n matrix of signed 16-bit words from storage and prints it as decimal ASCII
// over UART, space-separated within a row and CR/LF terminated per row.
module uart_matrix_printer
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic [7:0]  i_base_addr,
  input  logic [2:0]  i_m,
  input  logic [2:0]  i_n,
  output logic [7:0]  o_rd_addr,
  input  logic [31:0] i_rd_data,
  output logic        uart_tx,
  output logic        o_busy,
  output logic        o_done
);
  localparam int unsigned DIV = baud_div(CLK_FREQ, BAUD);

  state_e      state_q;
  logic [7:0]  rd_addr_q;
  logic [2:0]  m_q, n_q, row_q, col_q, wi_q, dig_idx_q;
  logic        neg_q, busy_q, done_q, tx_start_q;
  logic [7:0]  tx_data_q;
  logic [16:0] rem_q;
  digits_t     dig_q;

  logic        tx_busy, tx_ready, last_col, last_row;
  logic [15:0] rd_val;
  logic [16:0] rd_mag_d, weight_d;
  logic        unused_rd_hi;

  assign rd_val   = i_rd_data[15:0];
  // 17-bit magnitude so that -32768 negates without overflow.
  assign rd_mag_d = rd_val[15] ? (17'd0 - {1'b1, rd_val}) : {1'b0, rd_val};
  assign weight_d = dec_weight(wi_q);
  assign tx_ready = !tx_busy && !tx_start_q;
  assign last_col = (col_q == n_q - 3'd1);
  assign last_row = (row_q == m_q - 3'd1);
  assign unused_rd_hi = ^i_rd_data[31:16];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rd_addr_q  <= '0;
      m_q        <= '0;
      n_q        <= '0;
      row_q      <= '0;
      col_q      <= '0;
      wi_q       <= '0;
      dig_idx_q  <= '0;
      neg_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      rem_q      <= '0;
      dig_q      <= '0;
    end else begin
      tx_start_q <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          busy_q <= 1'b0;
          if (i_start && !done_q) begin
            busy_q    <= 1'b1;
            rd_addr_q <= i_base_addr;
            m_q       <= i_m;
            n_q       <= i_n;
            row_q     <= '0;
            col_q     <= '0;
            state_q   <= (i_m == 3'd0 || i_n == 3'd0) ? ST_DONE : ST_RD_REQ;
          end
        end
        ST_RD_REQ: state_q <= ST_RD_WAIT;
        ST_RD_WAIT: begin
          neg_q   <= rd_val[15];
          rem_q   <= rd_mag_d;
          dig_q   <= '0;
          wi_q    <= '0;
          state_q <= ST_CONV;
        end
        ST_CONV: begin
          if (rem_q >= weight_d) begin
            rem_q        <= rem_q - weight_d;
            dig_q[wi_q]  <= dig_q[wi_q] + 4'd1;
          end else if (wi_q == 3'd3) begin
            dig_q[4] <= rem_q[3:0];
            state_q  <= ST_SEND_SIGN;
          end else begin
            wi_q <= wi_q + 3'd1;
          end
        end
        ST_SEND_SIGN: begin
          if (!neg_q || tx_ready) begin
            tx_start_q <= neg_q;
            tx_data_q  <= ASCII_MINUS;
            dig_idx_q  <= first_digit(dig_q);
            state_q    <= ST_SEND_DIG;
          end
        end
        ST_SEND_DIG: begin
          if (tx_ready) begin
            tx_start_q <= 1'b1;
            tx_data_q  <= ASCII_ZERO + {4'd0, dig_q[dig_idx_q]};
            if (dig_idx_q == 3'd4) state_q <= last_col ? ST_SEND_CR : ST_SEND_SEP;
            else dig_idx_q <= dig_idx_q + 3'd1;
          end
        end
        ST_SEND_SEP: begin
          if (tx_ready) begin
            tx_start_q <= 1'b1;
            tx_data_q  <= ASCII_SPACE;
            col_q      <= col_q + 3'd1;
            rd_addr_q  <= rd_addr_q + 8'd1;
            state_q    <= ST_RD_REQ;
          end
        end
        ST_SEND_CR: begin
          if (tx_ready) begin
            tx_start_q <= 1'b1;
            tx_data_q  <= ASCII_CR;
            state_q    <= ST_SEND_LF;
          end
        end
        ST_SEND_LF: begin
          if (tx_ready) begin
            tx_start_q <= 1'b1;
            tx_data_q  <= ASCII_LF;
            col_q      <= '0;
            if (last_row) begin
              state_q <= ST_DONE;
            end else begin
              row_q     <= row_q + 3'd1;
              rd_addr_q <= rd_addr_q + 8'd1;
              state_q   <= ST_RD_REQ;
            end
          end
        end
        ST_DONE: begin
          // Wait for the final stop bit to leave the line before signalling completion.
          if (tx_ready) begin
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  uart_tx_core #(.DIV(DIV)) u_tx (
    .clk      (clk),
    .rst_n    (rst_n),
    .tx_start (tx_start_q),
    .tx_data  (tx_data_q),
    .tx_busy  (tx_busy),
    .tx       (uart_tx)
  );

  assign o_rd_addr = rd_addr_q;
  assign o_busy    = busy_q;
  assign o_done    = done_q;

endmodule

// File: tb/tb_uart_matrix_printer.sv
// Directed bench for uart_matrix_printer: table of matrices with expected text, plus reset,
// empty-matrix, start-while-busy and frame-shape sequences.
module tb_uart_matrix_printer;

  logic        clk;
  logic        rst_n;
  logic        i_start;
  logic [7:0]  i_base_addr;
  logic [2:0]  i_m;
  logic [2:0]  i_n;
  logic [7:0]  o_rd_addr;
  logic [31:0] i_rd_data;
  logic        uart_tx;
  logic        o_busy;
  logic        o_done;

  uart_matrix_printer #(.CLK_FREQ(1000), .BAUD(100)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (i_start),
    .i_base_addr (i_base_addr),
    .i_m         (i_m),
    .i_n         (i_n),
    .o_rd_addr   (o_rd_addr),
    .i_rd_data   (i_rd_data),
    .uart_tx     (uart_tx),
    .o_busy      (o_busy),
    .o_done      (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [256];
  always @(posedge clk) i_rd_data <= mem[o_rd_addr];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  // UART line monitor: samples every cycle of a frame so bit widths are checked too.
  logic [7:0]  rx_q [$];
  logic        mon_en = 1'b1;
  logic        line_prev = 1'b1;
  logic [99:0] mon_s, mon_exp;
  logic [7:0]  mon_b;
  always begin
    @(negedge clk);
    if (mon_en && rst_n === 1'b1 && uart_tx === 1'b0 && line_prev) begin
      mon_s    = '0;
      mon_s[0] = uart_tx;
      for (int k = 1; k < 100; k++) begin
        @(negedge clk);
        mon_s[k] = uart_tx;
      end
      for (int j = 0; j < 8; j++) mon_b[j] = mon_s[15 + 10 * j];
      for (int k = 0; k < 100; k++)
        mon_exp[k] = (k < 10) ? 1'b0 : (k >= 90) ? 1'b1 : mon_b[k / 10 - 1];
      n_checks++;
      if (mon_s !== mon_exp) begin
        n_fail++;
        $display("FAIL frame_shape: byte %02h line %025h required %025h", mon_b, mon_s, mon_exp);
      end
      rx_q.push_back(mon_b);
    end
    line_prev = uart_tx;
  end

  int done_cnt = 0;
  always @(negedge clk) if (o_done === 1'b1) done_cnt++;

  logic [7:0] addr_q [$];
  logic       addr_valid = 1'b0;
  logic [7:0] addr_last;
  always @(negedge clk) begin
    if (o_busy === 1'b1 && (!addr_valid || o_rd_addr != addr_last)) begin
      addr_q.push_back(o_rd_addr);
      addr_last  = o_rd_addr;
      addr_valid = 1'b1;
    end
  end

  typedef struct {
    logic [7:0]       base;
    logic [2:0]       m;
    logic [2:0]       n;
    logic [31:0]      data [6];
    logic [8*32-1:0]  text;
  } vec_t;
  vec_t vecs [4];

  function automatic int slen(input logic [8*32-1:0] s);
    int l = 0;
    for (int i = 0; i < 32; i++) if (s[8*i +: 8] != 8'd0) l++;
    return l;
  endfunction

  task automatic run_vec(input int vi, input bit spam);
    vec_t       v;
    int         cyc, first_low, len, ne;
    bit         seen, busy_again;
    logic [7:0] a, eb;
    v = vecs[vi];
    for (int k = 0; k < int'(v.m) * int'(v.n); k++) begin
      a = 8'(int'(v.base) + k);
      mem[a] = v.data[k];
    end
    rx_q.delete();
    addr_q.delete();
    addr_valid = 1'b0;
    done_cnt   = 0;
    first_low  = -1;
    @(negedge clk);
    i_base_addr = v.base;
    i_m         = v.m;
    i_n         = v.n;
    i_start     = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    cyc  = 1;
    seen = (o_done === 1'b1);
    while (!seen && cyc < 8000) begin
      if (spam) begin
        i_start     = (cyc % 5 == 2);
        i_base_addr = 8'($urandom);
        i_m         = 3'($urandom);
        i_n         = 3'($urandom);
      end
      @(negedge clk);
      cyc++;
      if (first_low < 0 && uart_tx === 1'b0) first_low = cyc;
      if (o_done === 1'b1) seen = 1'b1;
    end
    chk($sformatf("v%0d_done_seen", vi), int'(seen), 1);
    if (spam) i_start = 1'b1;
    @(negedge clk);
    i_start    = 1'b0;
    busy_again = 1'b0;
    repeat (150) begin
      @(negedge clk);
      if (o_busy !== 1'b0) busy_again = 1'b1;
    end
    chk($sformatf("v%0d_busy_after_done", vi), int'(busy_again), 0);
    chk($sformatf("v%0d_done_count", vi), done_cnt, 1);
    if (vi == 0 && !spam)
      chk("v0_first_start_bit_within_50", int'(first_low > 0 && first_low <= 50), 1);
    len = slen(v.text);
    chk($sformatf("v%0d_byte_count", vi), rx_q.size(), len);
    for (int i = 0; i < len && i < rx_q.size(); i++) begin
      eb = v.text[8*(len-1-i) +: 8];
      chk($sformatf("v%0d_byte%0d", vi, i), int'(rx_q[i]), int'(eb));
    end
    ne = 0;
    for (int r = 0; r < int'(v.m); r++) begin
      for (int c = 0; c < int'(v.n); c++) begin
        a = 8'(int'(v.base) + r * int'(v.n) + c);
        if (ne < addr_q.size())
          chk($sformatf("v%0d_rd_addr%0d", vi, ne), int'(addr_q[ne]), int'(a));
        ne++;
      end
    end
    chk($sformatf("v%0d_rd_addr_count", vi), addr_q.size(), ne);
  endtask

  initial begin
    int  cyc;
    bit  low_seen;

    for (int i = 0; i < 256; i++) mem[i] = 32'd0;

    vecs[0].base = 8'h10; vecs[0].m = 3'd2; vecs[0].n = 3'd3;
    vecs[0].data = '{32'd1, 32'hFFFF_FFFE, 32'd0, 32'h0000_7FFF, 32'hFFFF_8000, 32'd10};
    vecs[0].text = 256'({"1 -2 0", 8'h0D, 8'h0A, "32767 -32768 10", 8'h0D, 8'h0A});
    vecs[1].base = 8'hFF; vecs[1].m = 3'd1; vecs[1].n = 3'd1;
    vecs[1].data = '{32'h0001_0005, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    vecs[1].text = 256'({"5", 8'h0D, 8'h0A});
    vecs[2].base = 8'hFF; vecs[2].m = 3'd1; vecs[2].n = 3'd2;
    vecs[2].data = '{32'h0001_0005, 32'h0000_FFFF, 32'd0, 32'd0, 32'd0, 32'd0};
    vecs[2].text = 256'({"5 -1", 8'h0D, 8'h0A});
    vecs[3].base = 8'h40; vecs[3].m = 3'd3; vecs[3].n = 3'd1;
    vecs[3].data = '{32'd100, 32'hFFFF_FFF7, 32'hABCD_3039, 32'd0, 32'd0, 32'd0};
    vecs[3].text = 256'({"100", 8'h0D, 8'h0A, "-9", 8'h0D, 8'h0A, "12345", 8'h0D, 8'h0A});

    rst_n = 1'b0; i_start = 1'b0; i_base_addr = '0; i_m = '0; i_n = '0;
    repeat (3) @(negedge clk);
    chk("reset_uart_tx", int'(uart_tx), 1);
    chk("reset_busy", int'(o_busy), 0);
    chk("reset_done", int'(o_done), 0);
    chk("reset_rd_addr", int'(o_rd_addr), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Reset in the middle of a frame.
    mon_en = 1'b0;
    for (int k = 0; k < 3; k++) mem[8'h40 + 8'(k)] = vecs[3].data[k];
    i_base_addr = 8'h40; i_m = 3'd3; i_n = 3'd1; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    cyc = 0;
    while (uart_tx !== 1'b0 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("midframe_tx_started", int'(uart_tx === 1'b0), 1);
    repeat (25) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midframe_reset_tx_high", int'(uart_tx), 1);
    chk("midframe_reset_busy", int'(o_busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    low_seen = 1'b0;
    repeat (120) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) low_seen = 1'b1;
    end
    chk("after_reset_line_idle", int'(low_seen), 0);
    mon_en = 1'b1;

    for (int vi = 0; vi < 4; vi++) run_vec(vi, 1'b0);

    // Empty matrix: no bytes, done two cycles after start.
    rx_q.delete();
    done_cnt = 0;
    @(negedge clk);
    i_base_addr = 8'h20; i_m = 3'd0; i_n = 3'd4; i_start = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      i_start = 1'b0;
      chk($sformatf("m0_busy_cycle%0d", k), int'(o_busy), int'(k <= 2));
      chk($sformatf("m0_done_cycle%0d", k), int'(o_done), int'(k == 2));
    end
    low_seen = 1'b0;
    repeat (200) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) low_seen = 1'b1;
    end
    chk("m0_line_high", int'(low_seen), 0);
    chk("m0_rx_bytes", rx_q.size(), 0);
    chk("m0_done_count", done_cnt, 1);

    // Start pulses and input changes while busy, including in the done cycle.
    run_vec(0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d checks, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_matrix_printer.md
# uart_matrix_printer

Reads an m×n matrix of signed values from matrix storage and transmits it over UART as decimal ASCII text, row by row. It is the outbound counterpart of the input subsystem's ASCII-to-storage parser: that block turns received decimal text into storage words, and this block turns storage words back into decimal text. It sits beside the storage mux as a storage read client and drives the `uart_tx` pin. The display subsystem uses it for matrix and result printing.

## Interface
Parameters:
- `CLK_FREQ`, 100_000_000, system clock in Hz.
- `BAUD`, 115200, UART bit rate. Bit period is `CLK_FREQ/BAUD` cycles, truncated.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `i_start`  in  1  one-cycle start pulse. Ignored while `o_busy`=1.
- `i_base_addr`  in  8  storage address of element (0,0). Latched on start.
- `i_m`  in  3  row count, 0..5. Latched on start.
- `i_n`  in  3  column count, 0..5. Latched on start.
- `o_rd_addr`  out  8  storage read address.
- `i_rd_data`  in  32  storage read data. Valid one cycle after `o_rd_addr` is presented (synchronous read).
- `uart_tx`  out  1  serial line, idle high.
- `o_busy`  out  1  high from the cycle after an accepted start until the `o_done` cycle, inclusive.
- `o_done`  out  1  one-cycle pulse after the last stop bit.

## Operation
- Reset values: `uart_tx`=1, `o_busy`=0, `o_done`=0, `o_rd_addr`=0. The FSM goes to IDLE and the bit/baud counters clear. A reset mid-frame returns the line high immediately.
- Element (r,c) is read at address `base + r*n + c`, computed mod 256 (8-bit wrap).
- Each element is formatted from `i_rd_data[15:0]` as signed 16-bit:
  - A leading `'-'` (0x2D) is sent if the value is negative.
  - The magnitude is sent in decimal with leading zeros suppressed. Value 0 prints as `'0'`.
  - -32768 prints as `"-32768"`. Magnitude uses a 17-bit unsigned, so it does not overflow.
- Separators:
  - A space (0x20) follows each element except the last in its row.
  - Each row ends with CR (0x0D) then LF (0x0A).
- Digit extraction is repeated subtraction of 10000, 1000, 100, 10, counting each quotient digit. The remainder is the units digit. No divider is used.
- FSM states:
  - IDLE: on `i_start`, latch inputs. If m=0 or n=0, go to DONE. Otherwise go to RD_REQ.
  - RD_REQ: drive `o_rd_addr`.
  - RD_WAIT: capture `i_rd_data` next cycle.
  - CONV: extract digits into a 5-digit buffer plus a sign flag. Takes at most 45 cycles.
  - SEND_SIGN: send `'-'` if the sign flag is set.
  - SEND_DIG: send digits from the first nonzero digit onward.
  - SEND_SEP: send a space, then advance the column and go to RD_REQ. Taken when c<n-1.
  - SEND_CR, then SEND_LF: taken at row end. Advance the row; go to RD_REQ if rows remain, else DONE.
  - DONE: pulse `o_done`, return to IDLE.
- Byte handshake to the TX core:
  - `tx_start` is asserted for one cycle only when `tx_busy`=0.
  - The FSM waits while `tx_busy`=1 and never issues two bytes in the same frame.
- Frame format: 8N1, LSB first. Start bit 0, 8 data bits, stop bit 1.

## Timing
- The first start bit appears no later than 50 cycles after an accepted `i_start`: 2 read cycles, up to 45 conversion cycles, plus handshake.
- Each byte occupies exactly 10×(`CLK_FREQ/BAUD`) cycles on the line.
- Between consecutive bytes of the same element there is at most 2 cycles of idle line.
- `o_done` is asserted 1 cycle after the final LF stop bit completes.
- With m=0 or n=0, `o_done` is asserted 2 cycles after start and the line stays high.
- `i_start` arriving in the same cycle as `o_done` is ignored. A new start is accepted only in IDLE.
- Input changes after start have no effect on a print in progress.

## Structure
- Shared package `uart_pkg`:
  - ASCII constants: SPACE, CR, LF, MINUS, ZERO.
  - FSM state enum.
  - Decimal weight constants.
  - The baud-divider function.
- Sub-module `uart_tx_core`:
  - Ports: `clk`, `rst_n`, `tx_start`, `tx_data[7:0]`, `tx_busy`, `tx`.
  - Contains the baud counter and bit counter.
  - Reused by any other transmitter in the design.
- Top level holds the FSM, the row/column counters, the address adder, and the digit converter.

## Test plan
Use `CLK_FREQ`=1000 and `BAUD`=100 (10 cycles/bit). Decode the line with a bench UART monitor.
- Reset: hold `rst_n`=0 -> `uart_tx`=1, `o_busy`=0, `o_done`=0. Assert reset mid-frame -> line high the next cycle, then a fresh start works.
- Matrix 2×3 at base 0x10, data {1,-2,0; 32767,-32768,10} -> bytes `"1 -2 0\r\n32767 -32768 10\r\n"`, read addresses 0x10..0x15, exactly one `o_done`.
- Matrix 1×1, base 0xFF, data at 0xFF = 0x0001_0005 (upper bits ignored) -> `"5\r\n"`. Matrix 1×2 at 0xFF -> reads 0xFF then 0x00 (wrap).
- m=0, n=4 -> no start bit ever, `o_done` 2 cycles after start, `o_busy` high for 2 cycles.
- Extra `i_start` pulses while busy, including in the `o_done` cycle -> ignored; output is identical to a single print.
- Frame timing: check each bit is 10 cycles wide and the stop bit is high, for byte 0x2D.
